// File: rtl/alarm_controller_pkg.sv
// Shared types, widths and time constants for the alarm controller slice.
package alarm_controller_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_t;

    // True when h:m is a legal time of day.
    function automatic logic time_valid(input logic [HOUR_W-1:0] h,
                                        input logic [MIN_W-1:0]  m);
        return (h < HOUR_W'(HOURS_PER_DAY)) && (m < MIN_W'(MIN_PER_HOUR));
    endfunction

endpackage

// File: rtl/alarm_controller_hm_add.sv
// hours:minutes + N minutes, wrapping past 23:59 to the next day.
// Inputs are assumed to be a legal time and N is at most 59, so at most
// one hour carry can occur.
module hm_add
    import alarm_controller_pkg::*;
#(
    parameter int N = 5
)
(
    input  logic [HOUR_W-1:0] h_in,
    input  logic [MIN_W-1:0]  m_in,
    output logic [HOUR_W-1:0] h_out,
    output logic [MIN_W-1:0]  m_out
);

    localparam int SUM_W = MIN_W + 1;
    localparam logic [SUM_W-1:0]  ADD    = SUM_W'(N);
    localparam logic [SUM_W-1:0]  WRAP   = SUM_W'(MIN_PER_HOUR);
    localparam logic [HOUR_W-1:0] H_LAST = HOUR_W'(HOURS_PER_DAY - 1);

    logic [SUM_W-1:0] m_sum;

    // Add the offset, fold minutes back below 60 and carry into the hour.
    always_comb begin
        m_sum = {1'b0, m_in} + ADD;
        h_out = h_in;
        m_out = m_sum[MIN_W-1:0];
        if (m_sum >= WRAP) begin
            m_out = MIN_W'(m_sum - WRAP);
            h_out = (h_in == H_LAST) ? '0 : h_in + HOUR_W'(1);
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: stores an alarm time, watches the running clock from
// digital_clock and drives ringing / snooze status for the buzzer logic.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | alarm disabled (arm low)
//   ST_ARMED   | waiting for the clock to reach the target time
//   ST_RINGING | alarm sounding; ring timer running
//   ST_SNOOZE  | silenced; waiting for the snooze target time
module alarm_controller
    import alarm_controller_pkg::*;
#(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNOOZE = 3
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [SEC_W-1:0]  seconds,
    input  logic [MIN_W-1:0]  minutes,
    input  logic [HOUR_W-1:0] hours,
    input  logic              arm,
    input  logic              set_en,
    input  logic [HOUR_W-1:0] set_hours,
    input  logic [MIN_W-1:0]  set_minutes,
    input  logic              snooze,
    input  logic              dismiss,
    output logic [HOUR_W-1:0] alarm_hours,
    output logic [MIN_W-1:0]  alarm_minutes,
    output logic              armed,
    output logic              ringing,
    output logic              snooze_active,
    output logic [1:0]        snooze_count
);

    localparam logic [7:0] RING_LOAD = 8'(RING_SEC);
    localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZE);

    state_t            state, state_nxt;
    logic [SEC_W-1:0]  seconds_q;
    logic [HOUR_W-1:0] alarm_h, alarm_h_nxt;
    logic [MIN_W-1:0]  alarm_m, alarm_m_nxt;
    logic [HOUR_W-1:0] target_h, target_h_nxt;
    logic [MIN_W-1:0]  target_m, target_m_nxt;
    logic [7:0]        ring_left, ring_left_nxt;
    logic [1:0]        snz_cnt, snz_cnt_nxt;

    logic              sec_chg;
    logic              hit;
    logic              set_ok;
    logic              ring_done;
    logic [HOUR_W-1:0] snz_h;
    logic [MIN_W-1:0]  snz_m;

    hm_add #(
        .N (SNOOZE_MIN)
    ) u_snooze_add (
        .h_in  (hours),
        .m_in  (minutes),
        .h_out (snz_h),
        .m_out (snz_m)
    );

    // Event decode: a new second, the target minute starting, a legal set.
    // The ring timer counts down from RING_SEC; the second change that
    // would take it to zero ends the ring.
    always_comb begin
        sec_chg   = (seconds != seconds_q);
        hit       = sec_chg && (seconds == '0) &&
                    (hours == target_h) && (minutes == target_m);
        set_ok    = set_en && time_valid(set_hours, set_minutes);
        ring_done = sec_chg && (ring_left == 8'd1);
    end

    // Next-state logic, in priority order: disarm, set, dismiss, timeout,
    // snooze, hit.
    always_comb begin
        state_nxt     = state;
        alarm_h_nxt   = alarm_h;
        alarm_m_nxt   = alarm_m;
        target_h_nxt  = target_h;
        target_m_nxt  = target_m;
        ring_left_nxt = ring_left;
        snz_cnt_nxt   = snz_cnt;

        if (!arm) begin
            state_nxt   = ST_IDLE;
            snz_cnt_nxt = '0;
        end else if (set_ok) begin
            // A new alarm time restarts the event from scratch, including
            // when leaving IDLE on the same cycle.
            alarm_h_nxt  = set_hours;
            alarm_m_nxt  = set_minutes;
            target_h_nxt = set_hours;
            target_m_nxt = set_minutes;
            snz_cnt_nxt  = '0;
            state_nxt    = ST_ARMED;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nxt    = ST_ARMED;
                    target_h_nxt = alarm_h;
                    target_m_nxt = alarm_m;
                end
                ST_ARMED: begin
                    if (hit) begin
                        state_nxt     = ST_RINGING;
                        ring_left_nxt = RING_LOAD;
                    end
                end
                ST_RINGING: begin
                    if (dismiss || ring_done) begin
                        state_nxt    = ST_ARMED;
                        snz_cnt_nxt  = '0;
                        target_h_nxt = alarm_h;
                        target_m_nxt = alarm_m;
                    end else begin
                        if (sec_chg) begin
                            ring_left_nxt = ring_left - 8'd1;
                        end
                        // Once the snooze budget is spent the button is ignored.
                        if (snooze && (snz_cnt < SNZ_MAX)) begin
                            state_nxt    = ST_SNOOZE;
                            snz_cnt_nxt  = snz_cnt + 2'd1;
                            target_h_nxt = snz_h;
                            target_m_nxt = snz_m;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (dismiss) begin
                        state_nxt    = ST_ARMED;
                        snz_cnt_nxt  = '0;
                        target_h_nxt = alarm_h;
                        target_m_nxt = alarm_m;
                    end else if (hit) begin
                        state_nxt     = ST_RINGING;
                        ring_left_nxt = RING_LOAD;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            seconds_q <= '0;
            alarm_h   <= '0;
            alarm_m   <= '0;
            target_h  <= '0;
            target_m  <= '0;
            ring_left <= '0;
            snz_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            seconds_q <= seconds;
            alarm_h   <= alarm_h_nxt;
            alarm_m   <= alarm_m_nxt;
            target_h  <= target_h_nxt;
            target_m  <= target_m_nxt;
            ring_left <= ring_left_nxt;
            snz_cnt   <= snz_cnt_nxt;
        end
    end

    // Status outputs are pure decodes of registered state.
    always_comb begin
        alarm_hours   = alarm_h;
        alarm_minutes = alarm_m;
        armed         = (state != ST_IDLE);
        ringing       = (state == ST_RINGING);
        snooze_active = (state == ST_SNOOZE);
        snooze_count  = snz_cnt;
    end

endmodule
